// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Phase encodings and shared widths for the intersection
//               right-of-way scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam int c_phase_w = 3;

    typedef enum logic [c_phase_w-1:0] {
        A_GREEN   = 3'd0,
        A_YELLOW  = 3'd1,
        ALLRED_AB = 3'd2,
        B_GREEN   = 3'd3,
        B_YELLOW  = 3'd4,
        ALLRED_BA = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/traffic_phase_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_scheduler_if
// Description : Sensor inputs and lamp outputs of the phase scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_phase_scheduler_if;
    import traffic_pkg::*;

    logic                 sa;
    logic                 sb;
    logic                 ped_req;
    logic                 preempt;
    logic                 ga;
    logic                 ya;
    logic                 ra;
    logic                 gb;
    logic                 yb;
    logic                 rb;
    logic                 walk;
    logic                 ped_pending;
    logic [c_phase_w-1:0] phase;

    modport master (
        output sa, sb, ped_req, preempt,
        input  ga, ya, ra, gb, yb, rb, walk, ped_pending, phase
    );

    modport slave (
        input  sa, sb, ped_req, preempt,
        output ga, ya, ra, gb, yb, rb, walk, ped_pending, phase
    );

endinterface
`default_nettype wire

// File: rtl/traffic_phase_scheduler_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divider producing a one-clk tick every TICK_DIV
//               clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                c_cnt_w = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_scheduler
// Description : Tick-timed two-street right-of-way scheduler with pedestrian
//               walk, all-red clearance, B max-green and emergency preempt.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = 16,
    parameter int MIN_GREEN_A = 6,
    parameter int MIN_GREEN_B = 5,
    parameter int MAX_GREEN_B = 12,
    parameter int YELLOW_T    = 1,
    parameter int ALLRED_T    = 1,
    parameter int WALK_T      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    traffic_phase_scheduler_if.slave  bus
);

    // Sum of all dwell limits bounds every single one, so the saturating
    // counter can always represent N-1 for any phase.
    localparam int c_max_t   = MIN_GREEN_A + MAX_GREEN_B + YELLOW_T + ALLRED_T + WALK_T;
    localparam int c_dwell_w = $clog2(c_max_t + 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [c_dwell_w-1:0]   r_dwell;
    logic                   r_ped_pending;
    logic                   w_tick;

    logic w_done_min_a;
    logic w_done_min_b;
    logic w_done_max_b;
    logic w_done_yel;
    logic w_done_ar;
    logic w_done_walk;

    logic w_ga, w_ya, w_ra, w_gb, w_yb, w_rb, w_walk;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // ">=" keeps a phase exitable on any later tick once its minimum elapsed.
    assign w_done_min_a = w_tick && (r_dwell >= c_dwell_w'(MIN_GREEN_A - 1));
    assign w_done_min_b = w_tick && (r_dwell >= c_dwell_w'(MIN_GREEN_B - 1));
    assign w_done_max_b = w_tick && (r_dwell >= c_dwell_w'(MAX_GREEN_B - 1));
    assign w_done_yel   = w_tick && (r_dwell >= c_dwell_w'(YELLOW_T - 1));
    assign w_done_ar    = w_tick && (r_dwell >= c_dwell_w'(ALLRED_T - 1));
    assign w_done_walk  = w_tick && (r_dwell >= c_dwell_w'(WALK_T - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= A_GREEN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            A_GREEN: begin
                if (w_done_min_a && (bus.sb || r_ped_pending) && !bus.preempt) begin
                    w_next = A_YELLOW;
                end
            end
            A_YELLOW: begin
                if (w_done_yel) begin
                    w_next = ALLRED_AB;
                end
            end
            ALLRED_AB: begin
                if (w_done_ar) begin
                    if (bus.preempt) begin
                        w_next = ALLRED_BA;
                    end else if (r_ped_pending) begin
                        w_next = PED_WALK;
                    end else begin
                        w_next = B_GREEN;
                    end
                end
            end
            B_GREEN: begin
                if (bus.preempt || w_done_max_b ||
                    (w_done_min_b && (!bus.sb || bus.sa || r_ped_pending))) begin
                    w_next = B_YELLOW;
                end
            end
            B_YELLOW: begin
                if (w_done_yel) begin
                    w_next = ALLRED_BA;
                end
            end
            ALLRED_BA: begin
                if (w_done_ar) begin
                    w_next = A_GREEN;
                end
            end
            PED_WALK: begin
                if (bus.preempt) begin
                    w_next = ALLRED_BA;
                end else if (w_done_walk) begin
                    w_next = bus.sb ? B_GREEN : ALLRED_BA;
                end
            end
            default: w_next = ALLRED_BA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell <= '0;
        end else if (w_next != r_state) begin
            r_dwell <= '0;
        end else if (w_tick && (r_dwell != '1)) begin
            r_dwell <= r_dwell + c_dwell_w'(1);
        end
    end

    // Entering the walk phase serves the request and takes priority over a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ped_pending <= 1'b0;
        end else if ((w_next == PED_WALK) && (r_state != PED_WALK)) begin
            r_ped_pending <= 1'b0;
        end else if (bus.ped_req && (r_state != PED_WALK)) begin
            r_ped_pending <= 1'b1;
        end
    end

    always_comb begin
        w_ga   = 1'b0;
        w_ya   = 1'b0;
        w_ra   = 1'b1;
        w_gb   = 1'b0;
        w_yb   = 1'b0;
        w_rb   = 1'b1;
        w_walk = 1'b0;
        case (r_state)
            A_GREEN:  begin w_ga = 1'b1; w_ra = 1'b0; end
            A_YELLOW: begin w_ya = 1'b1; w_ra = 1'b0; end
            B_GREEN:  begin w_gb = 1'b1; w_rb = 1'b0; end
            B_YELLOW: begin w_yb = 1'b1; w_rb = 1'b0; end
            PED_WALK: w_walk = 1'b1;
            default:  ;
        endcase
    end

    assign bus.ga          = w_ga;
    assign bus.ya          = w_ya;
    assign bus.ra          = w_ra;
    assign bus.gb          = w_gb;
    assign bus.yb          = w_yb;
    assign bus.rb          = w_rb;
    assign bus.walk        = w_walk;
    assign bus.ped_pending = r_ped_pending;
    assign bus.phase       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_scheduler
// Description : Directed self-checking bench for the phase scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_scheduler;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   cyc;

    traffic_phase_scheduler_if bif ();

    traffic_phase_scheduler #(
        .TICK_DIV    (4),
        .MIN_GREEN_A (6),
        .MIN_GREEN_B (5),
        .MAX_GREEN_B (12),
        .YELLOW_T    (1),
        .ALLRED_T    (1),
        .WALK_T      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        bif.sa = 1'b1; bif.sb = 1'b0; bif.ped_req = 1'b0; bif.preempt = 1'b0;
        do_reset();
        n_cmp++;
        if (bif.phase !== 3'd0) begin
            n_bad++; $display("FAIL reset_phase: got %0d want 0", bif.phase);
        end
        n_cmp++;
        if ({bif.ga, bif.ya, bif.ra, bif.gb, bif.yb, bif.rb, bif.walk, bif.ped_pending} !== 8'b1000_0100) begin
            n_bad++;
            $display("FAIL reset_lamps: got %b want 10000100",
                     {bif.ga, bif.ya, bif.ra, bif.gb, bif.yb, bif.rb, bif.walk, bif.ped_pending});
        end
        for (int i = 0; i < 150; i++) begin
            run_to(cyc + 1);
            n_cmp++;
            if (bif.phase !== 3'd0 || bif.ga !== 1'b1 || bif.rb !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_a_green cyc %0d: phase=%0d ga=%b rb=%b want 0/1/1",
                         cyc, bif.phase, bif.ga, bif.rb);
            end
        end
    endtask

    // Reset lands mid-prescaler-count (150 mod 4 != 0); exact timing proves restart.
    task automatic test_a_to_b;
        do_reset();
        bif.sa = 1'b0; bif.sb = 1'b1;
        n_cmp++;
        if (bif.phase !== 3'd0) begin
            n_bad++; $display("FAIL midrun_reset_phase: got %0d want 0", bif.phase);
        end
        run_to(23);
        n_cmp++;
        if (bif.phase !== 3'd0) begin
            n_bad++; $display("FAIL a_green_before_min: got %0d want 0", bif.phase);
        end
        run_to(24);
        n_cmp++;
        if (bif.phase !== 3'd1 || bif.ya !== 1'b1) begin
            n_bad++; $display("FAIL a_yellow_entry: phase=%0d ya=%b want 1/1", bif.phase, bif.ya);
        end
        run_to(27);
        n_cmp++;
        if (bif.phase !== 3'd1) begin
            n_bad++; $display("FAIL a_yellow_hold: got %0d want 1", bif.phase);
        end
        run_to(28);
        n_cmp++;
        if (bif.phase !== 3'd2 || bif.ra !== 1'b1 || bif.rb !== 1'b1) begin
            n_bad++; $display("FAIL allred_ab_entry: phase=%0d ra=%b rb=%b want 2/1/1", bif.phase, bif.ra, bif.rb);
        end
        run_to(32);
        n_cmp++;
        if (bif.phase !== 3'd3 || bif.ra !== 1'b1 || bif.gb !== 1'b1 || bif.ga !== 1'b0) begin
            n_bad++; $display("FAIL b_green_entry: phase=%0d ra=%b gb=%b ga=%b want 3/1/1/0",
                              bif.phase, bif.ra, bif.gb, bif.ga);
        end
    endtask

    task automatic test_max_green;
        run_to(79);
        n_cmp++;
        if (bif.phase !== 3'd3) begin
            n_bad++; $display("FAIL b_green_before_max: got %0d want 3", bif.phase);
        end
        run_to(80);
        n_cmp++;
        if (bif.phase !== 3'd4 || bif.yb !== 1'b1 || bif.ra !== 1'b1) begin
            n_bad++; $display("FAIL b_yellow_at_max: phase=%0d yb=%b ra=%b want 4/1/1", bif.phase, bif.yb, bif.ra);
        end
        run_to(84);
        n_cmp++;
        if (bif.phase !== 3'd5) begin
            n_bad++; $display("FAIL allred_ba_entry: got %0d want 5", bif.phase);
        end
        run_to(87);
        n_cmp++;
        if (bif.phase !== 3'd5) begin
            n_bad++; $display("FAIL allred_ba_hold: got %0d want 5", bif.phase);
        end
        run_to(88);
        n_cmp++;
        if (bif.phase !== 3'd0 || bif.ga !== 1'b1 || bif.rb !== 1'b1) begin
            n_bad++; $display("FAIL return_a_green: phase=%0d ga=%b rb=%b want 0/1/1", bif.phase, bif.ga, bif.rb);
        end
        bif.sb = 1'b0;
    endtask

    task automatic test_ped_walk;
        bif.sa = 1'b0; bif.sb = 1'b0; bif.ped_req = 1'b0; bif.preempt = 1'b0;
        do_reset();
        run_to(2);
        bif.ped_req = 1'b1;
        run_to(3);
        bif.ped_req = 1'b0;
        n_cmp++;
        if (bif.ped_pending !== 1'b1) begin
            n_bad++; $display("FAIL ped_latch: got %b want 1", bif.ped_pending);
        end
        run_to(24);
        n_cmp++;
        if (bif.phase !== 3'd1) begin
            n_bad++; $display("FAIL ped_a_yellow: got %0d want 1", bif.phase);
        end
        run_to(28);
        n_cmp++;
        if (bif.phase !== 3'd2 || bif.ped_pending !== 1'b1) begin
            n_bad++; $display("FAIL ped_allred_ab: phase=%0d pend=%b want 2/1", bif.phase, bif.ped_pending);
        end
        run_to(31);
        bif.ped_req = 1'b1;
        run_to(32);
        n_cmp++;
        if (bif.phase !== 3'd6 || bif.walk !== 1'b1 || bif.ped_pending !== 1'b0) begin
            n_bad++; $display("FAIL walk_entry_clear_wins: phase=%0d walk=%b pend=%b want 6/1/0",
                              bif.phase, bif.walk, bif.ped_pending);
        end
        run_to(40);
        n_cmp++;
        if (bif.ped_pending !== 1'b0) begin
            n_bad++; $display("FAIL ped_ignored_in_walk: got %b want 0", bif.ped_pending);
        end
        run_to(47);
        bif.ped_req = 1'b0;
        n_cmp++;
        if (bif.phase !== 3'd6 || bif.walk !== 1'b1) begin
            n_bad++; $display("FAIL walk_last_clk: phase=%0d walk=%b want 6/1", bif.phase, bif.walk);
        end
        run_to(48);
        n_cmp++;
        if (bif.phase !== 3'd5 || bif.walk !== 1'b0) begin
            n_bad++; $display("FAIL walk_exit: phase=%0d walk=%b want 5/0", bif.phase, bif.walk);
        end
        run_to(52);
        n_cmp++;
        if (bif.phase !== 3'd0 || bif.ga !== 1'b1) begin
            n_bad++; $display("FAIL walk_back_a_green: phase=%0d ga=%b want 0/1", bif.phase, bif.ga);
        end
    endtask

    task automatic test_preempt_b;
        bif.sa = 1'b0; bif.sb = 1'b1; bif.ped_req = 1'b0; bif.preempt = 1'b0;
        do_reset();
        run_to(41);
        n_cmp++;
        if (bif.phase !== 3'd3) begin
            n_bad++; $display("FAIL preempt_setup_b_green: got %0d want 3", bif.phase);
        end
        bif.preempt = 1'b1;
        run_to(42);
        n_cmp++;
        if (bif.phase !== 3'd4) begin
            n_bad++; $display("FAIL preempt_immediate_b_yellow: got %0d want 4", bif.phase);
        end
        run_to(43);
        n_cmp++;
        if (bif.phase !== 3'd4) begin
            n_bad++; $display("FAIL preempt_yellow_not_shortened: got %0d want 4", bif.phase);
        end
        run_to(44);
        n_cmp++;
        if (bif.phase !== 3'd5) begin
            n_bad++; $display("FAIL preempt_allred_ba: got %0d want 5", bif.phase);
        end
        run_to(48);
        n_cmp++;
        if (bif.phase !== 3'd0 || bif.ga !== 1'b1) begin
            n_bad++; $display("FAIL preempt_a_green: phase=%0d ga=%b want 0/1", bif.phase, bif.ga);
        end
        for (int i = 0; i < 60; i++) begin
            run_to(cyc + 1);
            n_cmp++;
            if (bif.phase !== 3'd0) begin
                n_bad++; $display("FAIL preempt_hold_a cyc %0d: got %0d want 0", cyc, bif.phase);
            end
        end
        bif.preempt = 1'b0;
        bif.sb = 1'b0;
    endtask

    task automatic test_preempt_walk;
        bif.sa = 1'b0; bif.sb = 1'b0; bif.ped_req = 1'b0; bif.preempt = 1'b0;
        do_reset();
        run_to(2);
        bif.ped_req = 1'b1;
        run_to(3);
        bif.ped_req = 1'b0;
        run_to(32);
        n_cmp++;
        if (bif.phase !== 3'd6) begin
            n_bad++; $display("FAIL pw_walk_entry: got %0d want 6", bif.phase);
        end
        run_to(35);
        bif.preempt = 1'b1;
        run_to(36);
        n_cmp++;
        if (bif.phase !== 3'd5 || bif.walk !== 1'b0) begin
            n_bad++; $display("FAIL pw_immediate_exit: phase=%0d walk=%b want 5/0", bif.phase, bif.walk);
        end
        run_to(40);
        n_cmp++;
        if (bif.phase !== 3'd0) begin
            n_bad++; $display("FAIL pw_a_green: got %0d want 0", bif.phase);
        end
        bif.preempt = 1'b0;
    endtask

    task automatic test_illegal_state;
        run_to(cyc + 3);
        force dut.r_state = traffic_pkg::state_t'(3'd7);
        #1;
        release dut.r_state;
        #1;
        n_cmp++;
        if (bif.phase !== 3'd7 || bif.ra !== 1'b1 || bif.rb !== 1'b1 || bif.ga !== 1'b0 || bif.gb !== 1'b0) begin
            n_bad++; $display("FAIL illegal_decode: phase=%0d ra=%b rb=%b ga=%b gb=%b want 7/1/1/0/0",
                              bif.phase, bif.ra, bif.rb, bif.ga, bif.gb);
        end
        @(posedge clk);
        #1;
        cyc++;
        n_cmp++;
        if (bif.phase !== 3'd5 || bif.ra !== 1'b1 || bif.rb !== 1'b1) begin
            n_bad++; $display("FAIL illegal_recover: phase=%0d ra=%b rb=%b want 5/1/1", bif.phase, bif.ra, bif.rb);
        end
    endtask

    task automatic test_random_invariants;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            if ((i % 8) == 0) begin
                bif.sa      = 1'($urandom_range(0, 1));
                bif.sb      = 1'($urandom_range(0, 1));
                bif.preempt = ($urandom_range(0, 9) == 0);
            end
            bif.ped_req = ($urandom_range(0, 31) == 0);
            run_to(cyc + 1);
            n_cmp++;
            if (bif.ga === 1'b1 && bif.gb === 1'b1) begin
                n_bad++; $display("FAIL dual_green cyc %0d: ga=%b gb=%b want not both 1", cyc, bif.ga, bif.gb);
            end
            n_cmp++;
            if (({1'b0, bif.ga} + {1'b0, bif.ya} + {1'b0, bif.ra}) !== 2'd1 ||
                ({1'b0, bif.gb} + {1'b0, bif.yb} + {1'b0, bif.rb}) !== 2'd1) begin
                n_bad++; $display("FAIL one_lamp_per_street cyc %0d: A=%b%b%b B=%b%b%b want one-hot each",
                                  cyc, bif.ga, bif.ya, bif.ra, bif.gb, bif.yb, bif.rb);
            end
        end
        bif.sa = 1'b0; bif.sb = 1'b0; bif.ped_req = 1'b0; bif.preempt = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        bif.sa = 1'b0; bif.sb = 1'b0; bif.ped_req = 1'b0; bif.preempt = 1'b0;
        test_reset();
        test_a_to_b();
        test_max_green();
        test_ped_walk();
        test_preempt_b();
        test_preempt_walk();
        test_illegal_state();
        test_random_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
